// File: rtl/ika9958_cen_gen.sv
// Per-channel programmable divider: CH divided clocks with PCEN/NCEN edge enables, ratios reloaded at period boundaries.
// Optional external-pin phase realignment is built only when IKA9958_CEN_SYNC_EN is defined.
module ika9958_cen_gen #(
  parameter int                 CH       = 3,
  parameter int                 DW       = 4,
  parameter logic [CH*DW-1:0]   DIV_INIT = 12'h210
) (
  input  logic                  i_XTAL1,
  input  logic                  i_RST_n,
  input  logic                  i_XTAL_NCEN,
  input  logic [CH*DW-1:0]      i_DIV,
  input  logic                  i_DIV_LD,
  input  logic                  i_SYNC_n,
  input  logic [CH-1:0]         i_SYNC_MASK,
  output logic [CH-1:0]         o_CLK_n,
  output logic [CH-1:0]         o_PCEN,
  output logic [CH-1:0]         o_NCEN,
  output logic                  o_SYNCED
);

  logic [CH-1:0][DW-1:0] cnt_q, cnt_d;
  logic [CH-1:0][DW-1:0] act_q, act_d;
  logic [CH-1:0][DW-1:0] shd_q, shd_d;
  logic [CH-1:0]         clk_n_q, clk_n_d;
  logic                  synced_q, synced_d;

  logic [CH-1:0]         at_end;
  logic [CH-1:0]         hit;
  logic [CH-1:0]         sync_mask;
  logic                  sync_consume;
  logic                  all_natural;

`ifdef IKA9958_CEN_SYNC_EN
  // [0] first synchroniser stage, [1] synchronised pin, [2] previous synchronised value
  logic [2:0] sync_sr_q, sync_sr_d;
  logic       pend_q, pend_d;
  logic       sync_fall;

  always_comb begin
    sync_sr_d    = {sync_sr_q[1:0], i_SYNC_n};
    sync_fall    = sync_sr_q[2] & ~sync_sr_q[1];
    sync_consume = i_XTAL_NCEN & (pend_q | sync_fall);
    pend_d       = (pend_q | sync_fall) & ~i_XTAL_NCEN;
    sync_mask    = i_SYNC_MASK;
  end

  // Cleared to 0 so a pin already low when reset lifts is not mistaken for a fresh edge.
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sync_sr_q <= 3'b000;
      pend_q    <= 1'b0;
    end else begin
      sync_sr_q <= sync_sr_d;
      pend_q    <= pend_d;
    end
  end
`else
  logic sync_unused;
  assign sync_unused  = ^{i_SYNC_n, i_SYNC_MASK};
  assign sync_consume = 1'b0;
  assign sync_mask    = '0;
`endif

  always_comb begin
    synced_d    = synced_q;
    all_natural = 1'b1;
    for (int c = 0; c < CH; c++) begin
      at_end[c]  = (cnt_q[c] == act_q[c]);
      hit[c]     = sync_consume & sync_mask[c];
      shd_d[c]   = i_DIV_LD ? i_DIV[c*DW +: DW] : shd_q[c];
      cnt_d[c]   = cnt_q[c];
      clk_n_d[c] = clk_n_q[c];
      act_d[c]   = act_q[c];

      if (sync_mask[c] && !(at_end[c] && clk_n_q[c])) begin
        all_natural = 1'b0;
      end

      if (hit[c]) begin
        cnt_d[c]   = '0;
        clk_n_d[c] = 1'b0;
        act_d[c]   = shd_d[c];
      end else if (i_XTAL_NCEN) begin
        if (at_end[c]) begin
          cnt_d[c]   = '0;
          clk_n_d[c] = ~clk_n_q[c];
          // New ratio only at the falling edge, so no half-period is ever cut short.
          if (clk_n_q[c]) begin
            act_d[c] = shd_d[c];
          end
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end

      o_PCEN[c] = i_RST_n & i_XTAL_NCEN & ~hit[c] & at_end[c] & ~clk_n_q[c];
      o_NCEN[c] = i_RST_n & i_XTAL_NCEN & clk_n_q[c] & (hit[c] | at_end[c]);
    end
    if (sync_consume) begin
      synced_d = all_natural;
    end
  end

  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt_q    <= '0;
      clk_n_q  <= '1;
      act_q    <= DIV_INIT;
      shd_q    <= DIV_INIT;
      synced_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clk_n_q  <= clk_n_d;
      act_q    <= act_d;
      shd_q    <= shd_d;
      synced_q <= synced_d;
    end
  end

  assign o_CLK_n  = clk_n_q;
  assign o_SYNCED = synced_q;

endmodule

// File: tb/tb_ika9958_cen_gen.sv
// Bench for ika9958_cen_gen: directed scenarios plus random traffic, all checked against a
// tick-level phase model (position within each channel's period, ratio taken at each fall).
module tb_ika9958_cen_gen;
  localparam int               CH       = 3;
  localparam int               DW       = 4;
  localparam logic [CH*DW-1:0] DIV_INIT = 12'h210;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ncen = 1'b1;
  logic [CH*DW-1:0] div = DIV_INIT;
  logic            ld = 1'b0;
  logic            sync_n = 1'b1;
  logic [CH-1:0]   mask = '0;
  logic [CH-1:0]   o_clk_n, o_pcen, o_ncen;
  logic            o_synced;

  ika9958_cen_gen #(.CH(CH), .DW(DW), .DIV_INIT(DIV_INIT)) dut (
    .i_XTAL1    (clk),
    .i_RST_n    (rst_n),
    .i_XTAL_NCEN(ncen),
    .i_DIV      (div),
    .i_DIV_LD   (ld),
    .i_SYNC_n   (sync_n),
    .i_SYNC_MASK(mask),
    .o_CLK_n    (o_clk_n),
    .o_PCEN     (o_pcen),
    .o_NCEN     (o_ncen),
    .o_SYNCED   (o_synced)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: p = ticks into the current period (0..d low half, d+1..2d+1 high half).
  int          p    [CH];
  int          dcur [CH];
  int          shd  [CH];
  bit          m_synced;
  bit          pend;
  bit          s1, s2, s3;
  int          tick_no;
  logic [31:0] ncen_ev [CH];
  logic [31:0] pcen_ev [CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      dcur[c]    = int'(DIV_INIT[c*DW +: DW]);
      shd[c]     = dcur[c];
      p[c]       = dcur[c] + 1;
      ncen_ev[c] = '0;
      pcen_ev[c] = '0;
    end
    m_synced = 1'b0;
    pend     = 1'b0;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    tick_no  = 0;
  endtask

  // Entered between clock edges; leaves reset released right after a falling clock edge.
  task automatic do_reset();
    ncen  = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_clk_n", 32'(o_clk_n), 32'h7);
    chk("rst_pcen", 32'(o_pcen), 32'h0);
    chk("rst_ncen", 32'(o_ncen), 32'h0);
    chk("rst_synced", 32'(o_synced), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One master clock: drive inputs, check outputs before the edge, advance the model at the edge.
  task automatic cycle(input bit tk, input bit l, input logic [CH*DW-1:0] dv,
                       input bit sn, input logic [CH-1:0] mk);
    bit            fall_now, consume, all_nat, hit;
    logic [CH-1:0] e_p, e_n, e_clk;
    int            ns;
    ncen = tk; ld = l; div = dv; sync_n = sn; mask = mk;
    #2;
    fall_now = s3 & ~s2;
`ifdef IKA9958_CEN_SYNC_EN
    consume = tk & (pend | fall_now);
`else
    consume = 1'b0;
`endif
    if (tk) tick_no++;
    all_nat = 1'b1;
    for (int c = 0; c < CH; c++) begin
      hit      = consume & mk[c];
      e_clk[c] = (p[c] > dcur[c]);
      e_n[c]   = tk & (hit ? e_clk[c] : (p[c] == 2*dcur[c] + 1));
      e_p[c]   = tk & ~hit & (p[c] == dcur[c]);
      if (mk[c] && p[c] != 2*dcur[c] + 1) all_nat = 1'b0;
    end
    chk("clk_n", 32'(o_clk_n), 32'(e_clk));
    chk("pcen", 32'(o_pcen), 32'(e_p));
    chk("ncen", 32'(o_ncen), 32'(e_n));
    chk("synced", 32'(o_synced), 32'(m_synced));
    if (tk && tick_no < 32) begin
      for (int c = 0; c < CH; c++) begin
        ncen_ev[c][tick_no] = o_ncen[c];
        pcen_ev[c][tick_no] = o_pcen[c];
      end
    end
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      ns = l ? int'(dv[c*DW +: DW]) : shd[c];
      if (tk) begin
        if (consume && mk[c]) begin
          p[c] = 0; dcur[c] = ns;
        end else if (p[c] == 2*dcur[c] + 1) begin
          p[c] = 0; dcur[c] = ns;
        end else begin
          p[c]++;
        end
      end
      shd[c] = ns;
    end
    if (consume) m_synced = all_nat;
    pend = (pend | fall_now) & ~consume;
    s3 = s2; s2 = s1; s1 = sn;
    @(negedge clk);
  endtask

  // Event pattern over ticks 1..9 for the reset ratios (/2, /4, /6).
  task automatic check_default_events(input string tag);
    chk({tag, "_ch0_n"}, ncen_ev[0] & 32'h3FE, 32'h2AA);
    chk({tag, "_ch0_p"}, pcen_ev[0] & 32'h3FE, 32'h154);
    chk({tag, "_ch1_n"}, ncen_ev[1] & 32'h3FE, 32'h044);
    chk({tag, "_ch1_p"}, pcen_ev[1] & 32'h3FE, 32'h110);
    chk({tag, "_ch2_n"}, ncen_ev[2] & 32'h3FE, 32'h208);
    chk({tag, "_ch2_p"}, pcen_ev[2] & 32'h3FE, 32'h040);
  endtask

  initial begin
    logic [31:0]     r;
    bit              sn_r;
    logic [CH*DW-1:0] new_div;
    new_div = {4'd2, 4'd3, 4'd0};

    @(negedge clk); #3;
    do_reset();
    for (int t = 1; t <= 10; t++) cycle(1'b1, 1'b0, DIV_INIT, 1'b1, '0);
    check_default_events("free");

    #3; do_reset();
    for (int i = 0; i < 40; i++) cycle((i % 4) == 3, 1'b0, DIV_INIT, 1'b1, '0);
    check_default_events("sparse");

    // Ratio load mid low-half, then on the falling-edge tick itself.
    #3; do_reset();
    for (int t = 1; t <= 23; t++) cycle(1'b1, t == 3, new_div, 1'b1, '0);
    chk("ld_mid_ch1_falls", ncen_ev[1] & 32'hFFFFFE, 32'h404044);
    #3; do_reset();
    for (int t = 1; t <= 23; t++) cycle(1'b1, t == 6, new_div, 1'b1, '0);
    chk("ld_edge_ch1_falls", ncen_ev[1] & 32'hFFFFFE, 32'h404044);

    // Sync pulses consumed at ticks 7 (misaligned), 19 (aligned), 24 (misaligned).
    #3; do_reset();
    for (int t = 1; t <= 30; t++) begin
      cycle(1'b1, 1'b0, DIV_INIT, !(t == 5 || t == 6 || t == 17 || t == 18 || t == 22 || t == 23), 3'b110);
      if (t == 7) begin
`ifdef IKA9958_CEN_SYNC_EN
        chk("sync1_clk_n", 32'(o_clk_n[2:1]), 32'h0);
`else
        chk("sync1_clk_n", 32'(o_clk_n[2:1]), 32'h2);
`endif
        chk("sync1_synced", 32'(o_synced), 32'h0);
      end
      if (t == 19) begin
`ifdef IKA9958_CEN_SYNC_EN
        chk("sync2_synced", 32'(o_synced), 32'h1);
`else
        chk("sync2_synced", 32'(o_synced), 32'h0);
`endif
      end
      if (t == 24) chk("sync3_synced", 32'(o_synced), 32'h0);
    end

    // Sync left pending (no ticks) when reset hits; nothing may survive the reset.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, DIV_INIT, 1'b0, 3'b110);
    #3; do_reset();
    for (int t = 1; t <= 10; t++) cycle(1'b1, 1'b0, DIV_INIT, 1'b0, 3'b110);
    check_default_events("post_rst");

    // Random traffic.
    #3; do_reset();
    sn_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if ($urandom_range(0, 7) == 0) sn_r = ~sn_r;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, r[CH*DW-1:0], sn_r,
            CH'($urandom_range(0, (1 << CH) - 1)));
      if ($urandom_range(0, 499) == 0) begin
        #3; do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
